// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;

    localparam logic [AW-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_MDU
    } wb_grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering MDU writeback requests; DEPTH must be a power of two >= 2.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_req_t                wr_req,
    input  logic                   pop,
    output wb_req_t                rd_req,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_req  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_req;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (priority) and buffered MDU results.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN         = wb_pkg::XLEN,
    parameter int unsigned AW           = wb_pkg::AW,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_wb_valid,
    input  logic [AW-1:0]               pipe_wb_addr,
    input  logic [XLEN-1:0]             pipe_wb_data,
    input  logic                        mdu_valid,
    output logic                        mdu_ready,
    input  logic [AW-1:0]               mdu_addr,
    input  logic [XLEN-1:0]             mdu_data,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT == 0) begin : g_bad_cfg
        $error("wb_port_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT > 0");
    end

    wb_grant_e gnt;
    wb_req_t   head;
    wb_req_t   mdu_req;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    logic      pipe_req;

    assign mdu_ready = !fifo_full;
    assign pipe_req  = pipe_wb_valid && (pipe_wb_addr != REG_X0);
    assign fifo_push = mdu_valid && mdu_ready && (mdu_addr != REG_X0);
    assign fifo_pop  = (gnt == GNT_MDU);
    assign mdu_req   = '{addr: mdu_addr, data: mdu_data};

    wb_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .wr_req (mdu_req),
        .pop    (fifo_pop),
        .rd_req (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        gnt = GNT_NONE;
        if (pipe_req && !pipe_stall) gnt = GNT_PIPE;
        else if (!fifo_empty)        gnt = GNT_MDU;
    end

    // Stall is raised on the grant that brings the count to LIMIT, so it lands the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= 1'b0;
            if (fifo_pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (gnt == GNT_PIPE && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
                pipe_stall <= (starve_cnt == LIMIT - 1'b1);
            end
        end
    end
`else
    assign pipe_stall = 1'b0;

    always_comb begin
        gnt = GNT_NONE;
        if (pipe_req)         gnt = GNT_PIPE;
        else if (!fifo_empty) gnt = GNT_MDU;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= (gnt != GNT_NONE);
            case (gnt)
                GNT_PIPE: begin
                    rf_waddr <= pipe_wb_addr;
                    rf_wdata <= pipe_wb_data;
                end
                GNT_MDU: begin
                    rf_waddr <= head.addr;
                    rf_wdata <= head.data;
                end
                default: ;
            endcase
        end
    end

endmodule
